sa_axaddr_wrr_qos_arb: RTL and testbench
========================================

# sa_axaddr_wrr_qos_arb

Slave-side AxADDR arbiter for the AXI4 interconnect, generalising the fixed three-master address channel. Merges MST_AMT dispatcher address streams onto one slave AW/AR port. Arbitration is weighted round-robin with per-request QoS priority. The block adds a registered output stage, an outstanding-transaction limiter, and a write-order FIFO feed for the data channel.

## Interface
- MST_AMT, 4: number of master dispatchers.
- MST_WEIGHT, all 32'd1: packed `[0:MST_AMT*32-1]`; master 0's weight is the leftmost 32-bit field. Weight 0 is treated as 1.
- MST_ID_W, $clog2(MST_AMT): master index width.
- OUTSTANDING_AMT, 8: maximum accepted-but-not-done transactions.
- QOS_EN, 1: 0 disables QoS and gives pure WRR.
- ADDR_WIDTH 32, TRANS_MST_ID_W 5, TRANS_BURST_W 2, TRANS_DATA_LEN_W 8, TRANS_DATA_SIZE_W 3, TRANS_QOS_W 4.
- TRANS_SLV_ID_W, TRANS_MST_ID_W+MST_ID_W: width of the slave-side ID.
- ACLK_i  in  1  clock.
- ARESETn_i  in  1  synchronous, active-low reset.
- dsp_AxID_i / dsp_AxADDR_i / dsp_AxBURST_i / dsp_AxLEN_i / dsp_AxSIZE_i / dsp_AxQOS_i  in  field×MST_AMT  packed per-master fields; master i occupies slice i.
- dsp_AxVALID_i  in  MST_AMT  request valid.
- dsp_AxREADY_o  out  MST_AMT  one-hot accept.
- xDATA_stall_i  in  1  data channel cannot take a new order entry.
- s_done_i  in  1  one transaction completed (B/last-R returned).
- s_AxREADY_i  in  1  slave ready.
- s_AxID_o  out  TRANS_SLV_ID_W  {master index, AxID}.
- s_AxADDR_o / s_AxBURST_o / s_AxLEN_o / s_AxSIZE_o  out  field  registered payload.
- s_AxVALID_o  out  1  slave valid.
- xDATA_mst_id_o  out  MST_ID_W  master index of the accepted request.
- xDATA_AxLEN_o  out  TRANS_DATA_LEN_W  AxLEN of the accepted request.
- xDATA_fifo_order_wr_en_o  out  1  order-FIFO push.
- outst_cnt_o  out  $clog2(OUTSTANDING_AMT+1)  current outstanding count.

## Operation
- **Grant state:** `grant` (master index), `credit` (32-bit) and `ptr` (RR pointer).
- **Arbitration point:** occurs when `credit`==0, or when the granted master has dsp_AxVALID_i=0 while some other master is valid.
- **Arbitration decision:**
  - Candidates are the valid masters.
  - If QOS_EN, keep only the candidates with the highest AxQOS.
  - Among those, pick the first at or after `ptr` in round-robin order.
  - Set `grant` to the winner, load `credit` with the winner's weight, and set `ptr` to winner+1 (mod MST_AMT).
  - The decision is registered and takes effect in the next cycle.
- **QoS preemption:** QoS never preempts a grant that still has credit and a valid request.
- **Load enable:** `load` = granted master valid & `credit`≠0 & stage free & !xDATA_stall_i & outst_cnt_o<OUTSTANDING_AMT.
  - Stage free = !s_AxVALID_o | s_AxREADY_i.
- **On `load`:**
  - dsp_AxREADY_o[grant]=1 (combinational, one-hot).
  - The stage captures the payload, with s_AxID_o={grant, AxID}.
  - `credit` decrements.
  - The outstanding count increments.
  - xDATA_fifo_order_wr_en_o pulses with xDATA_mst_id_o=grant and xDATA_AxLEN_o=AxLEN.
- **Output stage:** holds s_AxVALID_o and payload stable until s_AxREADY_i.
- **Outstanding count:**
  - +1 on `load`, −1 on s_done_i; both in the same cycle leaves it unchanged.
  - s_done_i at count 0 is ignored.

## Timing
- **Reset outputs:** s_AxVALID_o=0, all payload outputs=0, dsp_AxREADY_o=0, xDATA_fifo_order_wr_en_o=0, outst_cnt_o=0.
- **Reset state:** grant=0, credit=0, ptr=0.
- **First arbitration:** in the first cycle after reset release with any request valid; the first `load` is one cycle later.
- **Latency:** `load` in cycle N gives s_AxVALID_o=1 with that payload in cycle N+1.
- **Throughput:** sustained 1 transfer/cycle while s_AxREADY_i=1 and credit remains.
- **Grant switch bubble:** one idle cycle per arbitration point.
- **Order-FIFO push:** xDATA_fifo_order_wr_en_o is coincident with dsp_AxREADY_o (cycle N), one pulse per accept.
- **Stall:** xDATA_stall_i=1 or count at limit blocks `load` in the same cycle. A transfer already in the stage still drains.
- **Reset mid-transfer:** a pending s_AxVALID_o is dropped, the count clears, and no order push is emitted.

## Test plan
1. **WRR order.** MST_AMT=3, MST_WEIGHT={5,3,2}, all valid continuously, equal QoS, s_AxREADY_i=1 → accept order M0×5, M1×3, M2×2, repeating; s_AxID_o[MSB-:2] matches the master.
2. **QoS selection.** All valid, M2 AxQOS=4, others 0 → M2 wins every arbitration point. A grant in progress to M0 finishes its remaining credit first.
3. **Backpressure.** s_AxREADY_i=0 for 4 cycles with the stage full → s_AxVALID_o=1, payload stable, dsp_AxREADY_o=0. On release, the transfer completes and a new accept occurs in the same cycle.
4. **Outstanding limit.** OUTSTANDING_AMT=8, s_done_i=0 → exactly 8 accepts, then outst_cnt_o=8 and dsp_AxREADY_o=0. One s_done_i pulse → exactly one more accept. s_done_i coincident with accept → count stays 8.
5. **Data-channel stall and order FIFO.** xDATA_stall_i=1 for 3 cycles → no accept and no order push. Over the whole run, order-push count = accept count, and the xDATA_mst_id_o sequence equals the grant sequence.
6. **Reset mid-operation.** Assert ARESETn_i=0 mid-burst → next cycle all outputs are 0 and outst_cnt_o=0. After release, arbitration restarts at M0.

Source files
------------

// File: rtl/sa_axaddr_wrr_qos_arb.sv
// sa_axaddr_wrr_qos_arb: weighted round-robin AxADDR arbiter with QoS priority,
// registered slave stage, outstanding limiter and write-order FIFO feed.
module sa_axaddr_wrr_qos_arb #(
  parameter int MST_AMT = 4,
  parameter logic [0:MST_AMT*32-1] MST_WEIGHT = {MST_AMT{32'd1}},
  parameter int MST_ID_W = $clog2(MST_AMT),
  parameter int OUTSTANDING_AMT = 8,
  parameter bit QOS_EN = 1'b1,
  parameter int ADDR_WIDTH = 32,
  parameter int TRANS_MST_ID_W = 5,
  parameter int TRANS_BURST_W = 2,
  parameter int TRANS_DATA_LEN_W = 8,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_QOS_W = 4,
  parameter int TRANS_SLV_ID_W = TRANS_MST_ID_W + MST_ID_W,
  localparam int CNT_W = $clog2(OUTSTANDING_AMT + 1)
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESETn_i,
  input  logic [MST_AMT*TRANS_MST_ID_W-1:0]     dsp_AxID_i,
  input  logic [MST_AMT*ADDR_WIDTH-1:0]         dsp_AxADDR_i,
  input  logic [MST_AMT*TRANS_BURST_W-1:0]      dsp_AxBURST_i,
  input  logic [MST_AMT*TRANS_DATA_LEN_W-1:0]   dsp_AxLEN_i,
  input  logic [MST_AMT*TRANS_DATA_SIZE_W-1:0]  dsp_AxSIZE_i,
  input  logic [MST_AMT*TRANS_QOS_W-1:0]        dsp_AxQOS_i,
  input  logic [MST_AMT-1:0]                    dsp_AxVALID_i,
  output logic [MST_AMT-1:0]                    dsp_AxREADY_o,
  input  logic                                  xDATA_stall_i,
  input  logic                                  s_done_i,
  input  logic                                  s_AxREADY_i,
  output logic [TRANS_SLV_ID_W-1:0]             s_AxID_o,
  output logic [ADDR_WIDTH-1:0]                 s_AxADDR_o,
  output logic [TRANS_BURST_W-1:0]              s_AxBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_AxLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_AxSIZE_o,
  output logic                                  s_AxVALID_o,
  output logic [MST_ID_W-1:0]                   xDATA_mst_id_o,
  output logic [TRANS_DATA_LEN_W-1:0]           xDATA_AxLEN_o,
  output logic                                  xDATA_fifo_order_wr_en_o,
  output logic [CNT_W-1:0]                      outst_cnt_o
);
  logic [MST_ID_W-1:0] grant, ptr, win;
  logic [31:0] credit, w_raw, win_weight;
  logic [TRANS_QOS_W-1:0] best_qos;
  logic [MST_AMT-1:0] cand;
  logic win_found, arb, load, stage_free, grant_valid, others_valid;
  logic [TRANS_MST_ID_W-1:0] sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [TRANS_BURST_W-1:0] sel_burst;
  logic [TRANS_DATA_LEN_W-1:0] sel_len;
  logic [TRANS_DATA_SIZE_W-1:0] sel_size;
  int idx;
  assign grant_valid = dsp_AxVALID_i[grant];
  assign others_valid = |(dsp_AxVALID_i & ~(MST_AMT'(1) << grant));
  assign stage_free = !s_AxVALID_o || s_AxREADY_i;
  // A grant holding credit and a valid request is never preempted, even by higher QoS
  assign arb = |dsp_AxVALID_i && (credit == '0 || (!grant_valid && others_valid));
  assign load = ARESETn_i && grant_valid && credit != '0 && stage_free && !xDATA_stall_i
                && outst_cnt_o < CNT_W'(OUTSTANDING_AMT);
  assign sel_id = dsp_AxID_i[int'(grant)*TRANS_MST_ID_W +: TRANS_MST_ID_W];
  assign sel_addr = dsp_AxADDR_i[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_burst = dsp_AxBURST_i[int'(grant)*TRANS_BURST_W +: TRANS_BURST_W];
  assign sel_len = dsp_AxLEN_i[int'(grant)*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
  assign sel_size = dsp_AxSIZE_i[int'(grant)*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
  assign dsp_AxREADY_o = load ? MST_AMT'(1) << grant : '0;
  assign xDATA_fifo_order_wr_en_o = load;
  assign xDATA_mst_id_o = grant;
  assign xDATA_AxLEN_o = load ? sel_len : '0;
  always_comb begin
    best_qos = '0;
    cand = '0;
    win = '0;
    win_found = 1'b0;
    w_raw = '0;
    idx = 0;
    for (int i = 0; i < MST_AMT; i++)
      if (dsp_AxVALID_i[i] && dsp_AxQOS_i[i*TRANS_QOS_W +: TRANS_QOS_W] > best_qos)
        best_qos = dsp_AxQOS_i[i*TRANS_QOS_W +: TRANS_QOS_W];
    for (int i = 0; i < MST_AMT; i++)
      cand[i] = dsp_AxVALID_i[i] && (!QOS_EN || dsp_AxQOS_i[i*TRANS_QOS_W +: TRANS_QOS_W] == best_qos);
    for (int k = 0; k < MST_AMT; k++) begin
      idx = int'(ptr) + k;
      idx = idx >= MST_AMT ? idx - MST_AMT : idx;
      if (!win_found && cand[idx]) begin
        win = MST_ID_W'(idx);
        win_found = 1'b1;
      end
    end
    for (int i = 0; i < MST_AMT; i++)
      if (win == MST_ID_W'(i)) w_raw = MST_WEIGHT[i*32 +: 32];
    win_weight = w_raw == '0 ? 32'd1 : w_raw;
  end
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      grant <= '0;
      credit <= '0;
      ptr <= '0;
    end else if (arb) begin
      grant <= win;
      credit <= win_weight;
      ptr <= win == MST_ID_W'(MST_AMT - 1) ? '0 : win + 1'b1;
    end else if (load) begin
      credit <= credit - 32'd1;
    end
  end
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i)
      outst_cnt_o <= '0;
    else
      outst_cnt_o <= outst_cnt_o + CNT_W'(load) - CNT_W'(s_done_i && outst_cnt_o != '0);
  end
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      s_AxVALID_o <= 1'b0;
      s_AxID_o <= '0;
      s_AxADDR_o <= '0;
      s_AxBURST_o <= '0;
      s_AxLEN_o <= '0;
      s_AxSIZE_o <= '0;
    end else if (load) begin
      s_AxVALID_o <= 1'b1;
      s_AxID_o <= {grant, sel_id};
      s_AxADDR_o <= sel_addr;
      s_AxBURST_o <= sel_burst;
      s_AxLEN_o <= sel_len;
      s_AxSIZE_o <= sel_size;
    end else if (s_AxREADY_i) begin
      s_AxVALID_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sa_axaddr_wrr_qos_arb.sv
// tb_sa_axaddr_wrr_qos_arb: randomized and directed bench for the AxADDR WRR/QoS arbiter
// against a cycle-level reference model of the arbitration rules.
module tb_sa_axaddr_wrr_qos_arb;
  localparam int N = 3;
  localparam int LIM = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*5-1:0] d_id = '0;
  logic [N*32-1:0] d_addr = '0;
  logic [N*2-1:0] d_burst = '0;
  logic [N*8-1:0] d_len = '0;
  logic [N*3-1:0] d_size = '0;
  logic [N*4-1:0] d_qos = '0;
  logic [N-1:0] d_valid = '0;
  logic [N-1:0] d_ready;
  logic stall = 1'b0, done = 1'b0, s_ready = 1'b0;
  logic [6:0] s_id;
  logic [31:0] s_addr;
  logic [1:0] s_burst;
  logic [7:0] s_len;
  logic [2:0] s_size;
  logic s_valid;
  logic [1:0] x_mst;
  logic [7:0] x_len;
  logic x_push;
  logic [3:0] outst;

  sa_axaddr_wrr_qos_arb #(
    .MST_AMT(N),
    .MST_WEIGHT({32'd5, 32'd3, 32'd2}),
    .OUTSTANDING_AMT(LIM)
  ) dut (
    .ACLK_i(clk),
    .ARESETn_i(rst_n),
    .dsp_AxID_i(d_id),
    .dsp_AxADDR_i(d_addr),
    .dsp_AxBURST_i(d_burst),
    .dsp_AxLEN_i(d_len),
    .dsp_AxSIZE_i(d_size),
    .dsp_AxQOS_i(d_qos),
    .dsp_AxVALID_i(d_valid),
    .dsp_AxREADY_o(d_ready),
    .xDATA_stall_i(stall),
    .s_done_i(done),
    .s_AxREADY_i(s_ready),
    .s_AxID_o(s_id),
    .s_AxADDR_o(s_addr),
    .s_AxBURST_o(s_burst),
    .s_AxLEN_o(s_len),
    .s_AxSIZE_o(s_size),
    .s_AxVALID_o(s_valid),
    .xDATA_mst_id_o(x_mst),
    .xDATA_AxLEN_o(x_len),
    .xDATA_fifo_order_wr_en_o(x_push),
    .outst_cnt_o(outst)
  );

  always #5 clk = ~clk;

  bit k_rst_n, k_ready, k_done, k_stall;
  logic [N-1:0] k_v;
  int k_qos[N];
  int w[N] = '{5, 3, 2};
  int pat[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2};
  logic [31:0] a_addr[N];
  int a_id[N], a_burst[N], a_len[N], a_size[N];
  int mg = 0, mc = 0, mp = 0, mcnt = 0, mid = 0, mburst = 0, mlen = 0, msize = 0;
  bit msv = 1'b0;
  logic [31:0] maddr = '0;
  int acc_q[$];
  int n_chk = 0, n_err = 0, n_acc = 0, n_push = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    int best, win, idx, el;
    logic [N-1:0] v;
    @(negedge clk);
    rst_n = k_rst_n;
    d_valid = k_v;
    s_ready = k_ready;
    done = k_done;
    stall = k_stall;
    for (int i = 0; i < N; i++) begin
      a_addr[i] = $urandom;
      a_id[i] = $urandom_range(0, 31);
      a_burst[i] = $urandom_range(0, 3);
      a_len[i] = $urandom_range(0, 255);
      a_size[i] = $urandom_range(0, 7);
      d_addr[i*32 +: 32] = a_addr[i];
      d_id[i*5 +: 5] = 5'(a_id[i]);
      d_burst[i*2 +: 2] = 2'(a_burst[i]);
      d_len[i*8 +: 8] = 8'(a_len[i]);
      d_size[i*3 +: 3] = 3'(a_size[i]);
      d_qos[i*4 +: 4] = 4'(k_qos[i]);
    end
    #1;
    v = k_v;
    el = (k_rst_n && v[mg] && mc != 0 && (!msv || k_ready) && !k_stall && mcnt < LIM) ? 1 : 0;
    chk("axready", 64'(d_ready), el != 0 ? 64'(1) << mg : 64'(0));
    chk("order_push", 64'(x_push), 64'(el));
    if (el != 0) begin
      chk("order_mst_id", 64'(x_mst), 64'(mg));
      chk("order_len", 64'(x_len), 64'(a_len[mg]));
      acc_q.push_back(mg);
    end
    chk("s_valid", 64'(s_valid), 64'(msv));
    chk("s_id", 64'(s_id), 64'(mid));
    chk("s_addr", 64'(s_addr), 64'(maddr));
    chk("s_burst", 64'(s_burst), 64'(mburst));
    chk("s_len", 64'(s_len), 64'(mlen));
    chk("s_size", 64'(s_size), 64'(msize));
    chk("outst", 64'(outst), 64'(mcnt));
    if (d_ready != '0) n_acc++;
    if (x_push) n_push++;
    if (!k_rst_n) begin
      mg = 0; mc = 0; mp = 0; mcnt = 0; msv = 0;
      mid = 0; maddr = '0; mburst = 0; mlen = 0; msize = 0;
    end else begin
      if (el != 0) begin
        msv = 1;
        mid = mg * 32 + a_id[mg];
        maddr = a_addr[mg];
        mburst = a_burst[mg];
        mlen = a_len[mg];
        msize = a_size[mg];
      end else if (k_ready) begin
        msv = 0;
      end
      mcnt = mcnt + el - ((k_done && mcnt > 0) ? 1 : 0);
      if (v != '0 && (mc == 0 || (!v[mg] && (v & ~(3'(1) << mg)) != '0))) begin
        best = -1;
        for (int i = 0; i < N; i++) if (v[i] && k_qos[i] > best) best = k_qos[i];
        win = -1;
        for (int k = 0; k < N; k++) begin
          idx = (mp + k) % N;
          if (win < 0 && v[idx] && k_qos[idx] == best) win = idx;
        end
        mg = win;
        mc = w[win];
        mp = (win + 1) % N;
      end else if (el != 0) begin
        mc--;
      end
    end
  endtask

  initial begin
    int bad, a0, p0, first;
    k_rst_n = 0; k_v = '0; k_ready = 1; k_done = 0; k_stall = 0;
    k_qos = '{0, 0, 0};
    repeat (3) cycle();
    k_rst_n = 1; k_v = 3'b111; k_done = 1;
    repeat (60) cycle();
    chk("wrr_count", 64'(acc_q.size() >= 20), 64'(1));
    for (int i = 0; i < 20 && i < acc_q.size(); i++) chk("wrr_order", 64'(acc_q[i]), 64'(pat[i % 10]));
    acc_q.delete();
    k_qos = '{0, 0, 4};
    repeat (40) cycle();
    bad = 0;
    for (int i = 6; i < acc_q.size(); i++) if (acc_q[i] != 2) bad++;
    chk("qos_only_m2", 64'(bad), 64'(0));
    chk("qos_count", 64'(acc_q.size() > 15), 64'(1));
    k_qos = '{0, 0, 0};
    a0 = n_acc;
    k_ready = 0;
    repeat (4) cycle();
    chk("bp_hold", 64'((n_acc - a0) <= 1), 64'(1));
    chk("bp_valid", 64'(s_valid), 64'(1));
    k_ready = 1;
    repeat (4) cycle();
    k_v = '0; k_done = 1;
    repeat (10) cycle();
    chk("drain", 64'(outst), 64'(0));
    k_done = 0; k_v = 3'b111; a0 = n_acc;
    repeat (25) cycle();
    chk("limit_acc", 64'(n_acc - a0), 64'(LIM));
    chk("limit_cnt", 64'(outst), 64'(LIM));
    chk("limit_ready", 64'(d_ready), 64'(0));
    a0 = n_acc; k_done = 1;
    cycle();
    k_done = 0;
    repeat (6) cycle();
    chk("one_more", 64'(n_acc - a0), 64'(1));
    k_done = 1;
    repeat (2) cycle();
    k_done = 0;
    repeat (4) cycle();
    chk("cnt_back", 64'(outst), 64'(LIM));
    k_done = 1;
    repeat (4) cycle();
    p0 = n_push; k_stall = 1;
    repeat (3) cycle();
    chk("stall_push", 64'(n_push - p0), 64'(0));
    k_stall = 0;
    repeat (5) cycle();
    k_rst_n = 0;
    cycle();
    k_rst_n = 1;
    acc_q.delete();
    cycle();
    chk("rst_valid", 64'(s_valid), 64'(0));
    chk("rst_cnt", 64'(outst), 64'(0));
    repeat (8) cycle();
    first = acc_q.size() > 0 ? acc_q[0] : -1;
    chk("rst_first_m0", 64'(first), 64'(0));
    for (int c = 0; c < 2500; c++) begin
      k_v = N'($urandom);
      for (int i = 0; i < N; i++) k_qos[i] = $urandom_range(0, 3);
      k_ready = $urandom_range(0, 3) != 0;
      k_done = $urandom_range(0, 2) == 0;
      k_stall = $urandom_range(0, 7) == 0;
      k_rst_n = $urandom_range(0, 299) != 0;
      cycle();
    end
    chk("push_eq_acc", 64'(n_push), 64'(n_acc));
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
